// File: rtl/lut_cfg_ctrl_if.sv
// rtl/lut_cfg_ctrl_if.sv - serial mask configuration handshake between config source and lut_cfg_ctrl
interface lut_cfg_ctrl_if;
    logic cfg_start;
    logic cfg_valid;
    logic cfg_bit;
    logic cfg_parity;
    logic cfg_ready;

    modport master (
        output cfg_start,
        output cfg_valid,
        output cfg_bit,
        output cfg_parity,
        input  cfg_ready
    );

    modport slave (
        input  cfg_start,
        input  cfg_valid,
        input  cfg_bit,
        input  cfg_parity,
        output cfg_ready
    );
endinterface

// File: rtl/lut_cfg_ctrl.sv
// rtl/lut_cfg_ctrl.sv - K-input LUT with parity-checked serial mask load and atomic commit
// Optional mask readback port enabled by LUT_CFG_READBACK_EN.
module lut_cfg_ctrl #(
    parameter int LUT_K = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    lut_cfg_ctrl_if.slave    cfg,
    input  logic [LUT_K-1:0] lut_in,
    output logic             lut_out,
    output logic             busy,
    output logic             configured,
    output logic             cfg_error
`ifdef LUT_CFG_READBACK_EN
    ,
    input  logic             rb_req,
    output logic             rb_valid,
    output logic             rb_bit
`endif
);
    localparam int MASK_W = 2 ** LUT_K;
    localparam logic [LUT_K-1:0] CNT_LAST = LUT_K'(MASK_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_RUN,
        ST_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [MASK_W-1:0] shadow_q, shadow_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [LUT_K-1:0]  cnt_q, cnt_d;
    logic              par_q, par_d;
    logic              configured_q, configured_d;
    logic              error_q, error_d;
    logic              lut_out_q, lut_out_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            shadow_q     <= '0;
            mask_q       <= '0;
            cnt_q        <= '0;
            par_q        <= 1'b0;
            configured_q <= 1'b0;
            error_q      <= 1'b0;
            lut_out_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            par_q        <= par_d;
            configured_q <= configured_d;
            error_q      <= error_d;
            lut_out_q    <= lut_out_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        mask_d       = mask_q;
        cnt_d        = cnt_q;
        par_d        = par_q;
        configured_d = configured_q;
        error_d      = error_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (cfg.cfg_start) begin
                    state_d  = ST_LOAD;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            ST_ERR: begin
                if (cfg.cfg_start) begin
                    state_d  = ST_LOAD;
                    cnt_d    = '0;
                    shadow_d = '0;
                    error_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                // A restart wins over a coincident bit, which is dropped.
                if (cfg.cfg_start) begin
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (cfg.cfg_valid) begin
                    shadow_d = {shadow_q[MASK_W-2:0], cfg.cfg_bit};
                    cnt_d    = cnt_q + LUT_K'(1);
                    if (cnt_q == CNT_LAST) begin
                        par_d   = cfg.cfg_parity;
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if ((^shadow_q) == par_q) begin
                    mask_d       = shadow_q;
                    configured_d = 1'b1;
                    error_d      = 1'b0;
                    state_d      = ST_RUN;
                end else begin
                    error_d = 1'b1;
                    state_d = ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Evaluation always reads the committed mask, never the shadow.
    assign lut_out_d = configured_q ? mask_q[lut_in] : 1'b0;

    assign cfg.cfg_ready = (state_q == ST_LOAD);
    assign busy          = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign configured    = configured_q;
    assign cfg_error     = error_q;
    assign lut_out       = lut_out_q;

`ifdef LUT_CFG_READBACK_EN
    logic             rb_valid_q, rb_valid_d;
    logic             rb_bit_q, rb_bit_d;
    logic [LUT_K-1:0] rb_cnt_q, rb_cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rb_valid_q <= 1'b0;
            rb_bit_q   <= 1'b0;
            rb_cnt_q   <= '0;
        end else begin
            rb_valid_q <= rb_valid_d;
            rb_bit_q   <= rb_bit_d;
            rb_cnt_q   <= rb_cnt_d;
        end
    end

    // rb_cnt_q is the index from the MSB of the next bit; wrap to 0 ends the stream.
    always_comb begin
        rb_valid_d = rb_valid_q;
        rb_bit_d   = rb_bit_q;
        rb_cnt_d   = rb_cnt_q;
        if (rb_valid_q) begin
            if (cfg.cfg_start || (rb_cnt_q == '0)) begin
                rb_valid_d = 1'b0;
                rb_bit_d   = 1'b0;
            end else begin
                rb_bit_d = mask_q[~rb_cnt_q];
                rb_cnt_d = rb_cnt_q + LUT_K'(1);
            end
        end else if ((state_q == ST_RUN) && rb_req && !cfg.cfg_start) begin
            rb_valid_d = 1'b1;
            rb_bit_d   = mask_q[MASK_W-1];
            rb_cnt_d   = LUT_K'(1);
        end
    end

    assign rb_valid = rb_valid_q;
    assign rb_bit   = rb_bit_q;
`endif
endmodule

// File: tb/tb_lut_cfg_ctrl.sv
// tb/tb_lut_cfg_ctrl.sv - directed self-checking bench for lut_cfg_ctrl (readback with LUT_CFG_READBACK_EN)
module tb_lut_cfg_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] lut_in;
    logic       lut_out, busy, configured, cfg_error;
`ifdef LUT_CFG_READBACK_EN
    logic       rb_req, rb_valid, rb_bit;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [15:0] model_mask = '0;
    logic        model_cfg = 1'b0;
    logic [3:0]  prev_in = '0;

    always #5 clk = ~clk;

    lut_cfg_ctrl_if cfg_if ();

    lut_cfg_ctrl #(.LUT_K(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg        (cfg_if.slave),
        .lut_in     (lut_in),
        .lut_out    (lut_out),
        .busy       (busy),
        .configured (configured),
        .cfg_error  (cfg_error)
`ifdef LUT_CFG_READBACK_EN
        ,
        .rb_req     (rb_req),
        .rb_valid   (rb_valid),
        .rb_bit     (rb_bit)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: check the result for the previously applied lut_in, then apply the next.
    task automatic step_lut(input logic [3:0] nxt);
        chk("lut_out", {31'd0, lut_out}, {31'd0, model_cfg ? model_mask[prev_in] : 1'b0});
        lut_in  = nxt;
        prev_in = nxt;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_lut_out"}, {31'd0, lut_out}, 32'd0);
        chk({tag, "_configured"}, {31'd0, configured}, 32'd0);
        chk({tag, "_cfg_error"}, {31'd0, cfg_error}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_cfg_ready"}, {31'd0, cfg_if.cfg_ready}, 32'd0);
    endtask

    // Full load from a negedge; pre junk bits followed by a restart exercise the abort path.
    task automatic load(input logic [15:0] m, input logic par, input bit gaps, input int pre, input bit exp_ok);
        logic exp_cfg;
        exp_cfg = exp_ok ? 1'b1 : model_cfg;
        cfg_if.cfg_start = 1'b1;
        @(negedge clk) step_lut(prev_in + 4'd1);
        cfg_if.cfg_start = 1'b0;
        chk("ready_after_start", {31'd0, cfg_if.cfg_ready}, 32'd1);
        for (int p = 0; p < pre; p++) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_bit   = 1'b1;
            @(negedge clk) step_lut(prev_in + 4'd3);
        end
        if (pre > 0) begin
            cfg_if.cfg_start = 1'b1;
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_bit   = 1'b1;
            @(negedge clk) step_lut(prev_in + 4'd5);
            cfg_if.cfg_start = 1'b0;
        end
        for (int i = 15; i >= 0; i--) begin
            if (gaps) begin
                cfg_if.cfg_valid = 1'b0;
                @(negedge clk) step_lut(prev_in + 4'd7);
            end
            chk("ready_loading", {31'd0, cfg_if.cfg_ready}, 32'd1);
            cfg_if.cfg_valid  = 1'b1;
            cfg_if.cfg_bit    = m[i];
            cfg_if.cfg_parity = (i == 0) ? par : ~par;
            @(negedge clk) step_lut(prev_in + 4'd1);
        end
        cfg_if.cfg_valid = 1'b0;
        chk("ready_in_check", {31'd0, cfg_if.cfg_ready}, 32'd0);
        chk("busy_in_check", {31'd0, busy}, 32'd1);
        @(negedge clk) step_lut(prev_in + 4'd1);
        chk("configured_after_check", {31'd0, configured}, {31'd0, exp_cfg});
        chk("cfg_error_after_check", {31'd0, cfg_error}, {31'd0, !exp_ok});
        chk("busy_after_check", {31'd0, busy}, 32'd0);
        if (exp_ok) begin
            model_mask = m;
            model_cfg  = 1'b1;
        end
    endtask

    task automatic sweep();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk) step_lut(4'(i));
        end
        @(negedge clk) step_lut(4'd0);
    endtask

    initial begin
        cfg_if.cfg_start  = 1'b0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_bit    = 1'b0;
        cfg_if.cfg_parity = 1'b0;
        lut_in            = 4'd0;
`ifdef LUT_CFG_READBACK_EN
        rb_req = 1'b0;
`endif
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk) step_lut(4'd0);

        // 6996 is the 4-input odd-parity function; XOR of its bits is 0.
        load(16'h6996, 1'b0, 1'b0, 0, 1'b1);
        sweep();

        // Bad parity: old mask must stay live throughout.
        load(16'h8000, 1'b0, 1'b0, 0, 1'b0);
        chk("err_keeps_configured", {31'd0, configured}, 32'd1);
        sweep();
        cfg_if.cfg_start = 1'b1;
        @(negedge clk) step_lut(4'd7);
        cfg_if.cfg_start = 1'b0;
        chk("err_cleared_by_start", {31'd0, cfg_error}, 32'd0);
        chk("ready_after_err_start", {31'd0, cfg_if.cfg_ready}, 32'd1);

        load(16'hFFFE, 1'b1, 1'b1, 0, 1'b1);
        @(negedge clk) step_lut(4'd0);
        @(negedge clk) step_lut(4'd9);
        @(negedge clk) step_lut(4'd9);
        chk("fffe_in9", {31'd0, lut_out}, 32'd1);

        load(16'h00FF, 1'b0, 1'b0, 7, 1'b1);
        @(negedge clk) step_lut(4'd0);
        @(negedge clk) step_lut(4'd8);
        @(negedge clk) step_lut(4'd8);

        // Asynchronous reset while running.
        @(negedge clk) reset_n = 1'b0;
        #1;
        chk_all_zero("reset_run");
        model_cfg  = 1'b0;
        model_mask = '0;
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk) step_lut(4'd1);

        load(16'h6996, 1'b0, 1'b0, 0, 1'b1);
        @(negedge clk) step_lut(4'd7);
        @(negedge clk) step_lut(4'd15);
        @(negedge clk) step_lut(4'd1);
        @(negedge clk) step_lut(4'd1);

`ifdef LUT_CFG_READBACK_EN
        chk("rb_idle", {31'd0, rb_valid}, 32'd0);
        rb_req = 1'b1;
        @(negedge clk) rb_req = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("rb_valid", {31'd0, rb_valid}, 32'd1);
            chk("rb_bit", {31'd0, rb_bit}, {31'd0, model_mask[15-k]});
            rb_req = (k == 3);
            @(negedge clk);
        end
        rb_req = 1'b0;
        chk("rb_done", {31'd0, rb_valid}, 32'd0);
`endif

        // Reset in the middle of a load after 7 bits.
        cfg_if.cfg_start = 1'b1;
        @(negedge clk) step_lut(4'd2);
        cfg_if.cfg_start = 1'b0;
        for (int p = 0; p < 7; p++) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_bit   = p[0];
            @(negedge clk) step_lut(4'd2);
        end
        chk("busy_mid_load", {31'd0, busy}, 32'd1);
        cfg_if.cfg_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_all_zero("reset_load");
        model_cfg = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk) step_lut(4'd1);
        @(negedge clk) step_lut(4'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
